reg_alu_exec_unit: RTL and testbench

// Parametrised execute stage: register file (NREGS x XLEN) feeding a 10-op ALU with a registered

---
 rtl/reg_alu_exec_unit.sv | 115 +++++++++++
 tb/tb_reg_alu_exec_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_alu_exec_unit.sv
// Execute stage: NREGS x XLEN register file feeding a 10-op ALU with a registered result,
// valid/ready on both sides, deferred write-back on result hand-off and EX->ID forwarding.
module reg_alu_exec_unit #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int IMM_W = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [$clog2(NREGS)-1:0] rs1,
    input  logic [$clog2(NREGS)-1:0] rs2,
    input  logic [$clog2(NREGS)-1:0] rd,
    input  logic [6:0]               opcode,
    input  logic [3:0]               Opsel,
    input  logic [IMM_W-1:0]         imm_in,
    input  logic                     reg_write,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          ALU_out,
    output logic                     zero_flag
);

    localparam int AW  = $clog2(NREGS);
    localparam int SHW = $clog2(XLEN);

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    // Destination of the result currently held in ALU_out, committed on hand-off.
    typedef struct packed {
        logic [AW-1:0] rd;
        logic          wr_en;
    } ex_tag_t;

    logic [XLEN-1:0] regfile [NREGS];
    ex_tag_t         ex_tag;

    logic                   in_fire, out_fire, legal, fwd_a, fwd_b;
    logic [XLEN-1:0]        op_a, rs2_val, op_b, imm_sext, alu_res;
    logic signed [IMM_W-1:0] imm_s;
    logic [SHW-1:0]         shamt;

    assign in_ready = reset & (~out_valid | out_ready);
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign legal    = (opcode == OP_R) || (opcode == OP_I);

    // A result waiting in EX is newer than the regfile copy of its destination.
    assign fwd_a = out_valid & ex_tag.wr_en & (ex_tag.rd == rs1) & (rs1 != '0);
    assign fwd_b = out_valid & ex_tag.wr_en & (ex_tag.rd == rs2) & (rs2 != '0);

    assign op_a    = (rs1 == '0) ? '0 : (fwd_a ? ALU_out : regfile[rs1]);
    assign rs2_val = (rs2 == '0) ? '0 : (fwd_b ? ALU_out : regfile[rs2]);

    assign imm_s    = imm_in;
    assign imm_sext = XLEN'(imm_s);
    assign op_b     = (opcode == OP_R) ? rs2_val : imm_sext;
    assign shamt    = op_b[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (Opsel)
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_SLL:  alu_res = op_a << shamt;
            ALU_SRL:  alu_res = op_a >> shamt;
            ALU_SRA:  alu_res = $signed(op_a) >>> shamt;
            ALU_SLT:  alu_res = XLEN'($signed(op_a) < $signed(op_b));
            ALU_SLTU: alu_res = XLEN'(op_a < op_b);
            default:  alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) regfile[i] <= '0;
            out_valid <= 1'b0;
            ALU_out   <= '0;
            zero_flag <= 1'b0;
            ex_tag    <= '0;
        end else begin
            if (out_fire && ex_tag.wr_en && (ex_tag.rd != '0))
                regfile[ex_tag.rd] <= ALU_out;
            // Illegal opcodes are consumed silently; the else-branch still retires any result.
            if (in_fire && legal) begin
                ALU_out      <= alu_res;
                zero_flag    <= (alu_res == '0);
                out_valid    <= 1'b1;
                ex_tag.rd    <= rd;
                ex_tag.wr_en <= reg_write;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reg_alu_exec_unit.sv
// Scoreboard bench for reg_alu_exec_unit: directed hazard/backpressure/reset cases plus a
// random instruction stream checked against an in-order architectural model.
module tb_reg_alu_exec_unit;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int IMM_W = 12;
    localparam int AW    = 5;
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_X = 7'b0000011;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [AW-1:0]    rs1, rs2, rd;
    logic [6:0]       opcode;
    logic [3:0]       Opsel;
    logic [IMM_W-1:0] imm_in;
    logic             reg_write;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  ALU_out;
    logic             zero_flag;

    logic dir_rdy, rnd_bp, rnd_rdy;
    assign out_ready = rnd_bp ? rnd_rdy : dir_rdy;

    reg_alu_exec_unit #(.XLEN(XLEN), .NREGS(NREGS), .IMM_W(IMM_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .rd(rd), .opcode(opcode), .Opsel(Opsel),
        .imm_in(imm_in), .reg_write(reg_write), .out_valid(out_valid),
        .out_ready(out_ready), .ALU_out(ALU_out), .zero_flag(zero_flag)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [XLEN-1:0] exp_q[$];
    logic [XLEN-1:0] mdl[NREGS];
    logic [XLEN-1:0] mon_exp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] alu_ref(input logic [3:0] sel,
                                                input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa;
        logic [XLEN-1:0] r;
        sa = a;
        case (sel)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = a << b[4:0];
            4'd6: r = a >> b[4:0];
            4'd7: r = sa >>> b[4:0];
            4'd8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9: r = (a < b) ? 32'd1 : 32'd0;
            default: r = '0;
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        #1 rnd_rdy = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
            else begin
                mon_exp = exp_q.pop_front();
                chk("alu_out", ALU_out, mon_exp);
                chk("zero_flag", zero_flag, (mon_exp == '0));
            end
        end
    end

    task automatic issue(input logic [AW-1:0] s1, input logic [AW-1:0] s2, input logic [AW-1:0] d,
                         input logic [6:0] opc, input logic [3:0] sel, input logic [IMM_W-1:0] imm,
                         input logic wr, input logic has_exp, input logic [XLEN-1:0] cexp);
        logic [XLEN-1:0] a, b, r;
        int t;
        rs1 = s1; rs2 = s2; rd = d; opcode = opc; Opsel = sel; imm_in = imm; reg_write = wr;
        in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            t++;
            @(negedge clk);
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        else if (opc == OP_R || opc == OP_I) begin
            a = (s1 == 0) ? '0 : mdl[s1];
            b = (opc == OP_R) ? ((s2 == 0) ? '0 : mdl[s2]) : {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
            r = alu_ref(sel, a, b);
            exp_q.push_back(has_exp ? cexp : r);
            if (wr && d != 0) mdl[d] = r;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        chk("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; in_valid = 1'b0; rs1 = '0; rs2 = '0; rd = '0; opcode = '0;
        Opsel = '0; imm_in = '0; reg_write = 1'b0; dir_rdy = 1'b1; rnd_bp = 1'b0;
        for (int i = 0; i < NREGS; i++) mdl[i] = '0;

        // Reset held two cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_alu_out", ALU_out, 0);
        chk("rst_in_ready", in_ready, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        for (int i = 1; i < NREGS; i++) issue(AW'(i), 0, 0, OP_R, 4'd0, 0, 0, 1, 0);

        // Back-to-back RAW hazard through forwarding
        issue(0, 0, 1, OP_I, 4'd0, 12'd5, 1, 1, 32'd5);
        issue(1, 1, 2, OP_R, 4'd0, 0, 1, 1, 32'd10);
        issue(2, 0, 0, OP_R, 4'd0, 0, 0, 1, 32'd10);

        // Sign extension, arithmetic shift, signed/unsigned compare
        issue(0, 0, 3, OP_I, 4'd0, 12'hFFF, 1, 1, 32'hFFFFFFFF);
        issue(3, 0, 4, OP_I, 4'd7, 12'd4, 1, 1, 32'hFFFFFFFF);
        issue(3, 0, 0, OP_R, 4'd8, 0, 0, 1, 32'd1);
        issue(3, 0, 0, OP_R, 4'd9, 0, 0, 1, 32'd0);

        // Zero flag and x0 write suppression
        issue(1, 1, 5, OP_R, 4'd1, 0, 1, 1, 32'd0);
        issue(0, 0, 0, OP_I, 4'd0, 12'd7, 1, 1, 32'd7);
        issue(0, 0, 0, OP_R, 4'd0, 0, 0, 1, 32'd0);
        drain();

        // Backpressure for three cycles, then release with a dependent instruction on the same edge
        dir_rdy = 1'b0;
        issue(0, 0, 6, OP_I, 4'd0, 12'd9, 1, 1, 32'd9);
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_alu_out", ALU_out, 32'd9);
        end
        @(posedge clk);
        #1 dir_rdy = 1'b1;
        issue(6, 0, 7, OP_I, 4'd0, 12'd1, 1, 1, 32'd10);
        chk("release_out_valid", out_valid, 1);
        chk("release_alu_out", ALU_out, 32'd10);
        issue(6, 0, 0, OP_R, 4'd0, 0, 0, 1, 32'd9);
        issue(7, 0, 0, OP_R, 4'd0, 0, 0, 1, 32'd10);
        drain();

        // Reset while a result is stalled
        dir_rdy = 1'b0;
        issue(0, 0, 8, OP_I, 4'd0, 12'd3, 1, 1, 32'd3);
        @(negedge clk);
        chk("pre_rst_out_valid", out_valid, 1);
        @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        for (int i = 0; i < NREGS; i++) mdl[i] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst2_out_valid", out_valid, 0);
        chk("rst2_alu_out", ALU_out, 0);
        chk("rst2_in_ready", in_ready, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        dir_rdy = 1'b1;
        issue(8, 0, 0, OP_R, 4'd0, 0, 0, 1, 32'd0);
        issue(1, 0, 0, OP_R, 4'd0, 0, 0, 1, 32'd0);
        drain();

        // Random stream over a small register window to provoke hazards
        rnd_bp = 1'b1;
        for (int n = 0; n < 300; n++) begin
            issue(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                  ($urandom_range(0, 7) == 0) ? OP_X : (($urandom_range(0, 1) == 0) ? OP_R : OP_I),
                  4'($urandom_range(0, 15)), IMM_W'($urandom), 1'($urandom_range(0, 1)), 1'b0, '0);
            if ($urandom_range(0, 5) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rnd_bp = 1'b0;
        drain();
        for (int i = 0; i < 8; i++) issue(AW'(i), 0, 0, OP_R, 4'd0, 0, 0, 1'b0, '0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
